// File: rtl/sync_fifo_pkg.sv
// ---------------------------------------------------------------------------
// sync_fifo_pkg
// Shared constants and helpers for the parametrised synchronous FIFO.
//   DefaultDataW / DefaultAddrW : default word width and address width
//   calcDepth()                 : number of storage entries for an address width
//   thresholdsLegal()           : checks almost_full / almost_empty thresholds
//                                 against the depth, used at elaboration time
// ---------------------------------------------------------------------------
package sync_fifo_pkg;

  localparam int DefaultDataW = 8;
  localparam int DefaultAddrW = 3;

  // Storage depth is always a power of two so pointers wrap for free.
  function automatic int calcDepth(input int addrW);
    return 1 << addrW;
  endfunction

  // almost_full threshold must lie in 1..DEPTH, almost_empty in 0..DEPTH-1.
  function automatic bit thresholdsLegal(input int addrW, input int afullTh,
                                         input int aemptyTh);
    int depth;
    depth = calcDepth(addrW);
    return (afullTh >= 1) && (afullTh <= depth) &&
           (aemptyTh >= 0) && (aemptyTh <= depth - 1);
  endfunction

endpackage

// File: rtl/ram_dp_regfile.sv
// ---------------------------------------------------------------------------
// ram_dp_regfile
// Dual-port register-file storage: one synchronous write port and one
// combinational read port. Every entry clears on the asynchronous reset.
// Ports:
//   clk        : clock, rising edge
//   rst_n      : asynchronous active-low reset
//   i_wrEn     : write strobe
//   i_wrAddr   : write address
//   i_wrData   : write data
//   i_rdAddr   : read address
//   o_rdData   : read data (combinational from i_rdAddr)
// ---------------------------------------------------------------------------
module ram_dp_regfile
  import sync_fifo_pkg::*;
#(
  parameter int DATA_W = DefaultDataW,
  parameter int ADDR_W = DefaultAddrW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_wrEn,
  input  logic [ADDR_W-1:0] i_wrAddr,
  input  logic [DATA_W-1:0] i_wrData,
  input  logic [ADDR_W-1:0] i_rdAddr,
  output logic [DATA_W-1:0] o_rdData
);

  localparam int DEPTH = calcDepth(ADDR_W);

  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_wrEn) begin
      r_mem[i_wrAddr] <= i_wrData;
    end
  end

  assign o_rdData = r_mem[i_rdAddr];

endmodule

// File: rtl/sync_fifo_param.sv
// ---------------------------------------------------------------------------
// sync_fifo_param
// Parametrised single-clock FIFO built from ram_dp_regfile plus pointer,
// occupancy and flag control. One write and one read may be accepted per
// cycle; rejected requests are reported as one-cycle overflow/underflow.
//
// Optional build macro: SYNC_FIFO_FWFT_EN
//   defined   : first-word-fall-through, rd_data shows the head word whenever
//               the FIFO is not empty and rd_en pops it
//   undefined : rd_data is registered and valid one cycle after the read
//
// Ports:
//   clk, rst_n    : clock (rising edge), asynchronous active-low reset
//   wr_en/wr_data : write request and data
//   rd_en         : read request (pop in FWFT mode)
//   rd_data       : read data
//   rd_valid      : rd_data holds a valid word
//   full/empty    : occupancy == DEPTH / == 0
//   almost_full   : occupancy >= AFULL_TH
//   almost_empty  : occupancy <= AEMPTY_TH
//   count         : occupancy, 0..DEPTH
//   overflow      : pulse, write was rejected because the FIFO was full
//   underflow     : pulse, read was rejected because the FIFO was empty
// ---------------------------------------------------------------------------
module sync_fifo_param
  import sync_fifo_pkg::*;
#(
  parameter int DATA_W    = DefaultDataW,
  parameter int ADDR_W    = DefaultAddrW,
  parameter int AFULL_TH  = 6,
  parameter int AEMPTY_TH = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow
);

  localparam int DEPTH = calcDepth(ADDR_W);

  localparam logic [ADDR_W:0] DepthV     = DEPTH[ADDR_W:0];
  localparam logic [ADDR_W:0] AfullThV   = AFULL_TH[ADDR_W:0];
  localparam logic [ADDR_W:0] AemptyThV  = AEMPTY_TH[ADDR_W:0];
  localparam logic [ADDR_W:0] PtrOne     = (ADDR_W + 1)'(1);

  if (!thresholdsLegal(ADDR_W, AFULL_TH, AEMPTY_TH)) begin : gen_badThresholds
    $error("sync_fifo_param: AFULL_TH or AEMPTY_TH outside legal range");
  end

  // Pointers carry one extra bit above the storage address; the low bits
  // index storage and the top bit toggles on every wrap.
  logic [ADDR_W:0]   r_wrPtr;
  logic [ADDR_W:0]   r_rdPtr;
  logic [ADDR_W:0]   r_count;
  logic              r_full;
  logic              r_empty;
  logic              r_afull;
  logic              r_aempty;
  logic              r_overflow;
  logic              r_underflow;

  logic              w_wrAcc;
  logic              w_rdAcc;
  logic [ADDR_W:0]   w_countNext;
  logic [DATA_W-1:0] w_ramRdData;

  // Accept decisions use the registered flags, so a full FIFO still pops
  // when both requests arrive and an empty FIFO still pushes.
  assign w_wrAcc = wr_en && !r_full;
  assign w_rdAcc = rd_en && !r_empty;

  always_comb begin
    w_countNext = r_count;
    if (w_wrAcc && !w_rdAcc) begin
      w_countNext = r_count + PtrOne;
    end else if (!w_wrAcc && w_rdAcc) begin
      w_countNext = r_count - PtrOne;
    end
  end

  // Every flag is derived from the next occupancy so that all of them line
  // up with count on the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wrPtr     <= '0;
      r_rdPtr     <= '0;
      r_count     <= '0;
      r_full      <= 1'b0;
      r_empty     <= 1'b1;
      r_afull     <= 1'b0;
      r_aempty    <= 1'b1;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wrAcc) begin
        r_wrPtr <= r_wrPtr + PtrOne;
      end
      if (w_rdAcc) begin
        r_rdPtr <= r_rdPtr + PtrOne;
      end
      r_count     <= w_countNext;
      r_full      <= (w_countNext == DepthV);
      r_empty     <= (w_countNext == '0);
      r_afull     <= (w_countNext >= AfullThV);
      r_aempty    <= (w_countNext <= AemptyThV);
      r_overflow  <= wr_en && r_full;
      r_underflow <= rd_en && r_empty;
    end
  end

  ram_dp_regfile #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_wrEn   (w_wrAcc),
    .i_wrAddr (r_wrPtr[ADDR_W-1:0]),
    .i_wrData (wr_data),
    .i_rdAddr (r_rdPtr[ADDR_W-1:0]),
    .o_rdData (w_ramRdData)
  );

`ifdef SYNC_FIFO_FWFT_EN
  // Head word is always on the output; rd_en only acknowledges it.
  assign rd_data  = w_ramRdData;
  assign rd_valid = !r_empty;
`else
  logic [DATA_W-1:0] r_rdData;
  logic              r_rdValid;

  // Registered read: capture the head word on the accepting edge and hold
  // it until the next accepted read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdData  <= '0;
      r_rdValid <= 1'b0;
    end else begin
      r_rdValid <= w_rdAcc;
      if (w_rdAcc) begin
        r_rdData <= w_ramRdData;
      end
    end
  end

  assign rd_data  = r_rdData;
  assign rd_valid = r_rdValid;
`endif

  assign full         = r_full;
  assign empty        = r_empty;
  assign almost_full  = r_afull;
  assign almost_empty = r_aempty;
  assign count        = r_count;
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

endmodule

// File: tb/tb_sync_fifo_param.sv
// ---------------------------------------------------------------------------
// tb_sync_fifo_param
// Self-checking bench for sync_fifo_param (8-bit x 8-entry, AFULL_TH=6,
// AEMPTY_TH=1). A queue-based reference model tracks the FIFO contents and
// is compared on every cycle; a hand-written vector table covers fill,
// overflow, drain and underflow, followed by wrap, mid-stream reset and a
// randomized run. Honours SYNC_FIFO_FWFT_EN for the read-side expectations.
// ---------------------------------------------------------------------------
module tb_sync_fifo_param;

  localparam int DATA_W    = 8;
  localparam int ADDR_W    = 3;
  localparam int DEPTH     = 8;
  localparam int AFULL_TH  = 6;
  localparam int AEMPTY_TH = 1;

  logic              clk;
  logic              rst_n;
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              rd_en;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic [ADDR_W:0]   count;
  logic              overflow;
  logic              underflow;

  int vectors;
  int miscompares;

  sync_fifo_param #(
    .DATA_W    (DATA_W),
    .ADDR_W    (ADDR_W),
    .AFULL_TH  (AFULL_TH),
    .AEMPTY_TH (AEMPTY_TH)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .rd_en        (rd_en),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  // 10 ns clock; inputs change and outputs are sampled on the falling edge.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case anything stalls.
  initial begin
    #2000000;
    $display("[TB] FAIL timeout: simulation did not finish, actual=running required=finished");
    $fatal(1, "[TB] timeout");
  end

  // Reference model: FIFO contents as a queue plus the last read result.
  logic [DATA_W-1:0] mQ[$];
  logic [DATA_W-1:0] mRdData;
  logic              mRdValid;
  logic              mOvf;
  logic              mUnf;

  task automatic modelReset();
    mQ.delete();
    mRdData  = '0;
    mRdValid = 1'b0;
    mOvf     = 1'b0;
    mUnf     = 1'b0;
  endtask

  task automatic modelStep(input logic wr, input logic rd, input logic [DATA_W-1:0] d);
    bit wasFull;
    bit wasEmpty;
    wasFull  = (mQ.size() == DEPTH);
    wasEmpty = (mQ.size() == 0);
    mOvf     = wr && wasFull;
    mUnf     = rd && wasEmpty;
    mRdValid = 1'b0;
    if (rd && !wasEmpty) begin
      mRdData  = mQ.pop_front();
      mRdValid = 1'b1;
    end
    if (wr && !wasFull) begin
      mQ.push_back(d);
    end
  endtask

  task automatic checkVal(input string name, input logic [31:0] actual,
                          input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
    end
  endtask

  // Compare every DUT output with the reference model.
  task automatic checkOutput(input string tag);
    int n;
    n = mQ.size();
    checkVal({tag, ".count"},        32'(count),        32'(n));
    checkVal({tag, ".full"},         32'(full),         32'(n == DEPTH));
    checkVal({tag, ".empty"},        32'(empty),        32'(n == 0));
    checkVal({tag, ".almost_full"},  32'(almost_full),  32'(n >= AFULL_TH));
    checkVal({tag, ".almost_empty"}, 32'(almost_empty), 32'(n <= AEMPTY_TH));
    checkVal({tag, ".overflow"},     32'(overflow),     32'(mOvf));
    checkVal({tag, ".underflow"},    32'(underflow),    32'(mUnf));
`ifdef SYNC_FIFO_FWFT_EN
    checkVal({tag, ".rd_valid"},     32'(rd_valid),     32'(n != 0));
    if (n != 0) begin
      checkVal({tag, ".rd_data"},    32'(rd_data),      32'(mQ[0]));
    end
`else
    checkVal({tag, ".rd_valid"},     32'(rd_valid),     32'(mRdValid));
    checkVal({tag, ".rd_data"},      32'(rd_data),      32'(mRdData));
`endif
  endtask

  // One clock of stimulus: drive at the falling edge, model the rising edge,
  // return at the next falling edge ready for checking.
  task automatic applyStimulus(input logic wr, input logic rd, input logic [DATA_W-1:0] d);
    wr_en   = wr;
    rd_en   = rd;
    wr_data = d;
    @(posedge clk);
    modelStep(wr, rd, d);
    @(negedge clk);
  endtask

  task automatic doReset();
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    wr_data = '0;
    rst_n   = 1'b0;
    modelReset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  typedef struct {
    logic              wr;
    logic              rd;
    logic [DATA_W-1:0] data;
    int                expCount;
    logic              expRdValid;
    logic [DATA_W-1:0] expRdData;
    logic              expOvf;
    logic              expUnf;
  } vec_t;

  vec_t vecs[20];

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b1;
    wr_en       = 1'b0;
    rd_en       = 1'b0;
    wr_data     = '0;

    // Fill with 0x11..0x18, overflow attempt, drain, underflow attempt.
    for (int i = 0; i < 8; i++) begin
      vecs[i] = '{1'b1, 1'b0, 8'(8'h11 + i), i + 1, 1'b0, 8'h00, 1'b0, 1'b0};
    end
    vecs[8] = '{1'b1, 1'b1, 8'hAA, 7, 1'b1, 8'h11, 1'b1, 1'b0};
    for (int i = 0; i < 7; i++) begin
      vecs[9 + i] = '{1'b0, 1'b1, 8'h00, 6 - i, 1'b1, 8'(8'h12 + i), 1'b0, 1'b0};
    end
    vecs[16] = '{1'b1, 1'b1, 8'h5C, 1, 1'b0, 8'h18, 1'b0, 1'b1};
    vecs[17] = '{1'b0, 1'b1, 8'h00, 0, 1'b1, 8'h5C, 1'b0, 1'b0};
    vecs[18] = '{1'b0, 1'b1, 8'h00, 0, 1'b0, 8'h5C, 1'b0, 1'b1};
    vecs[19] = '{1'b0, 1'b0, 8'h00, 0, 1'b0, 8'h5C, 1'b0, 1'b0};

    // Reset state.
    doReset();
    checkVal("reset.count",        32'(count),        32'd0);
    checkVal("reset.empty",        32'(empty),        32'd1);
    checkVal("reset.full",         32'(full),         32'd0);
    checkVal("reset.almost_empty", 32'(almost_empty), 32'd1);
    checkVal("reset.almost_full",  32'(almost_full),  32'd0);
    checkVal("reset.rd_valid",     32'(rd_valid),     32'd0);
    checkVal("reset.rd_data",      32'(rd_data),      32'd0);
    checkVal("reset.overflow",     32'(overflow),     32'd0);
    checkVal("reset.underflow",    32'(underflow),    32'd0);

    // Table-driven fill / overflow / drain / underflow.
    for (int i = 0; i < 20; i++) begin
      applyStimulus(vecs[i].wr, vecs[i].rd, vecs[i].data);
      checkVal($sformatf("row%0d.count", i),     32'(count),     32'(vecs[i].expCount));
      checkVal($sformatf("row%0d.overflow", i),  32'(overflow),  32'(vecs[i].expOvf));
      checkVal($sformatf("row%0d.underflow", i), 32'(underflow), 32'(vecs[i].expUnf));
`ifndef SYNC_FIFO_FWFT_EN
      checkVal($sformatf("row%0d.rd_valid", i),  32'(rd_valid),  32'(vecs[i].expRdValid));
      checkVal($sformatf("row%0d.rd_data", i),   32'(rd_data),   32'(vecs[i].expRdData));
`endif
      checkOutput($sformatf("row%0d", i));
    end

`ifdef SYNC_FIFO_FWFT_EN
    // First word falls through before any rd_en.
    doReset();
    applyStimulus(1'b1, 1'b0, 8'h11);
    checkVal("fwft.rd_valid", 32'(rd_valid), 32'd1);
    checkVal("fwft.rd_data",  32'(rd_data),  32'h11);
    applyStimulus(1'b1, 1'b0, 8'h12);
    applyStimulus(1'b0, 1'b1, 8'h00);
    checkVal("fwft.pop.rd_data", 32'(rd_data), 32'h12);
    checkOutput("fwft");
`endif

    // Continuous write+read at count=3; pointers wrap twice and order holds.
    doReset();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0, 8'(8'hE0 + i));
    end
    for (int k = 0; k < 20; k++) begin
      applyStimulus(1'b1, 1'b1, 8'(k));
      checkVal($sformatf("wrap%0d.count", k), 32'(count), 32'd3);
`ifndef SYNC_FIFO_FWFT_EN
      checkVal($sformatf("wrap%0d.rd_data", k), 32'(rd_data),
               (k < 3) ? 32'(8'hE0 + k) : 32'(k - 3));
`else
      checkVal($sformatf("wrap%0d.rd_data", k), 32'(rd_data),
               (k + 1 < 3) ? 32'(8'hE0 + k + 1) : 32'(k - 2));
`endif
      checkOutput($sformatf("wrap%0d", k));
    end

    // Asynchronous reset mid-stream at count=5.
    doReset();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, (i == 4), 8'(8'h30 + i));
    end
    applyStimulus(1'b1, 1'b0, 8'h35);
    checkVal("midrst.pre.count", 32'(count), 32'd5);
    wr_en = 1'b1;
    rd_en = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    modelReset();
    checkVal("midrst.count",    32'(count),    32'd0);
    checkVal("midrst.empty",    32'(empty),    32'd1);
    checkVal("midrst.full",     32'(full),     32'd0);
    checkVal("midrst.rd_data",  32'(rd_data),  32'd0);
    checkVal("midrst.rd_valid", 32'(rd_valid), 32'd0);
    wr_en = 1'b0;
    rd_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("midrst.after");

    // Randomized traffic, biased in phases to reach both full and empty.
    for (int c = 0; c < 400; c++) begin
      int wrPct;
      logic wr;
      logic rd;
      wrPct = ((c / 50) % 2 == 0) ? 75 : 25;
      wr    = ($urandom_range(99) < wrPct);
      rd    = ($urandom_range(99) < (100 - wrPct));
      applyStimulus(wr, rd, 8'($urandom));
      checkOutput($sformatf("rand%0d", c));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
- Parametrised single-clock FIFO: dual-port register-file storage plus pointer/flag control.
- Successor to the fixed 8x8 storage-only RAM: adds configurable width/depth, full/empty/almost flags, occupancy count, overflow/underflow reporting.
- Sits between a producer and consumer in the same clock domain; one write and one read per cycle.

Parameters:
- DATA_W, 8, data word width in bits (>=1).
- ADDR_W, 3, address width; DEPTH = 2**ADDR_W entries (>=1).
- AFULL_TH, 6, almost_full asserted when count >= AFULL_TH; legal 1..DEPTH.
- AEMPTY_TH, 1, almost_empty asserted when count <= AEMPTY_TH; legal 0..DEPTH-1.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- wr_en  input  1  write request.
- wr_data  input  DATA_W  write data.
- rd_en  input  1  read request.
- rd_data  output  DATA_W  read data.
- rd_valid  output  1  rd_data holds a newly popped word.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- almost_full  output  1  count >= AFULL_TH.
- almost_empty  output  1  count <= AEMPTY_TH.
- count  output  ADDR_W+1  current occupancy, 0..DEPTH.
- overflow  output  1  one-cycle pulse: write rejected.
- underflow  output  1  one-cycle pulse: read rejected.

Behaviour:
- Reset (async assert, sync release): wr_ptr = rd_ptr = 0, count 0, empty 1, full 0, almost_empty 1, almost_full 0, rd_data 0, rd_valid 0, overflow 0, underflow 0, all storage entries 0.
- Pointers are ADDR_W+1 bits; low ADDR_W bits address storage; wrap from DEPTH-1 to 0 with MSB toggle.
- Write accepted iff wr_en && !full (registered full). Data stored at wr_ptr on that edge; wr_ptr increments.
- Read accepted iff rd_en && !empty (registered empty). rd_ptr increments.
- Accept decisions use flags from before the edge:
  - Full with wr_en && rd_en: read accepted, write rejected, overflow pulses.
  - Empty with wr_en && rd_en: write accepted, read rejected, underflow pulses.
- Otherwise simultaneous accepted read+write: count unchanged; both pointers advance.
- count_next = count + wr_acc - rd_acc.
- All flags are registered from count_next, so they are always consistent with count in the same cycle.
- overflow = wr_en && full; underflow = rd_en && empty; each is a one-cycle registered pulse, high on the cycle after the request.
- Default (non-FWFT) read:
  - rd_data is registered, loaded on the edge that accepts the read, and is valid the following cycle (1-cycle latency).
  - rd_valid is high for exactly that cycle.
  - rd_data holds its value when no read is accepted.
- Write-to-read latency: a word written at edge N is readable (empty deasserted) after edge N; earliest rd_data at edge N+1.
- Reset mid-operation: all state returns to reset values immediately; in-flight data is discarded.

Optional Feature:
- Macro: SYNC_FIFO_FWFT_EN.
- Defined (first-word-fall-through):
  - rd_data is driven combinationally from storage[rd_ptr] whenever !empty.
  - rd_valid = !empty.
  - rd_en acts as a pop/acknowledge of the current word; no read latency.
  - rd_data is don't-care when empty; benches check it only while rd_valid.
- Undefined: registered 1-cycle read as described above.
- Flags, count, overflow and underflow are identical in both modes.

Decomposition:
- Package sync_fifo_pkg:
  - Default width/depth constants.
  - Function computing DEPTH from ADDR_W.
  - Threshold legality check, used in an elaboration-time assertion.
- Sub-module ram_dp_regfile (DATA_W, ADDR_W):
  - Async-reset storage array, synchronous write port.
  - Combinational read port.
  - Control and the read register live in sync_fifo_param.

Test Plan:
1. Reset, then write 0x11..0x18 (8 words) -> full=1 and almost_full=1 from the edge after the 8th write, count=8; almost_full first rises when count=6.
2. Read all 8 (non-FWFT) -> rd_data 0x11..0x18 in order, each with a one-cycle rd_valid; empty=1 and almost_empty=1 when count=0.
3. When full, drive wr_en=1 and rd_en=1 with wr_data=0xAA -> overflow pulses, head word is popped, count=7, 0xAA is not stored.
4. When empty, drive wr_en=1 and rd_en=1 with 0x5C -> underflow pulses, count=1, next read returns 0x5C.
5. Run 20 cycles of continuous write+read at count=3, pushing 0x00..0x13 -> count stays 3, pointers wrap at least twice, output order is preserved.
6. Assert rst_n low mid-stream at count=5 -> next sampled state is count=0, empty=1, rd_data=0. With SYNC_FIFO_FWFT_EN defined, rerun test 2 -> rd_data=0x11 visible before the first rd_en.
